// File: rtl/hist_ram_pkg.sv
// Shared defaults and types for the HIST_RAM histogram bin store.
package hist_ram_pkg;

  localparam int HIST_DATA_W = 32;
  localparam int HIST_ADDR_W = 5;

  typedef logic [HIST_DATA_W-1:0] hist_data_t;
  typedef logic [HIST_ADDR_W-1:0] hist_addr_t;

  localparam hist_data_t HIST_RESET_VAL = '0;

endpackage

// File: rtl/hist_ram_valid_tracker.sv
// Per-word valid flags: cleared by reset, set on write, looked up by read address.
module hist_ram_valid_tracker #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (set_en) begin
      valid[set_addr] <= 1'b1;
    end
  end

  // Pre-write flag value, so a same-edge write is not yet visible here.
  assign rd_valid = valid[rd_addr];

endmodule

// File: rtl/hist_sdp_ram.sv
// Simple dual-port histogram bin RAM: one write port, one registered read port.
module hist_sdp_ram
  import hist_ram_pkg::*;
#(
  parameter int                DATA_W    = HIST_DATA_W,
  parameter int                ADDR_W    = HIST_ADDR_W,
  parameter int                RDW_NEW   = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(HIST_RESET_VAL)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_fire;
  logic              rd_valid;
  logic              bypass;

  assign wr_fire = rst_n && wren;
  assign bypass  = (RDW_NEW != 0) && wr_fire && (wraddress == rdaddress);

  hist_ram_valid_tracker #(
    .ADDR_W (ADDR_W)
  ) u_valid (
    .clock    (clock),
    .rst_n    (rst_n),
    .set_en   (wren),
    .set_addr (wraddress),
    .rd_addr  (rdaddress),
    .rd_valid (rd_valid)
  );

  // NOTE: the array has no reset so it maps onto block RAM; the valid flags hide stale contents.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wraddress] <= data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (bypass) begin
      q <= data;
    end else begin
      q <= rd_valid ? mem[rdaddress] : RESET_VAL;
    end
  end

endmodule

// File: tb/tb_hist_sdp_ram.sv
// Self-checking bench for hist_sdp_ram: both read-during-write modes side by side.
module tb_hist_sdp_ram;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data = '0;
  logic [4:0]  wraddress = '0;
  logic        wren = 1'b0;
  logic [4:0]  rdaddress = '0;
  logic [31:0] q_old;
  logic [31:0] q_new;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: only words ever written since the last reset exist.
  logic [31:0] model [int];

  always #5 clock = ~clock;

  hist_sdp_ram #(.DATA_W(32), .ADDR_W(5), .RDW_NEW(0), .RESET_VAL(32'h0)) dut_old (
    .clock(clock), .rst_n(rst_n), .data(data), .wraddress(wraddress),
    .wren(wren), .rdaddress(rdaddress), .q(q_old)
  );

  hist_sdp_ram #(.DATA_W(32), .ADDR_W(5), .RDW_NEW(1), .RESET_VAL(32'h0)) dut_new (
    .clock(clock), .rst_n(rst_n), .data(data), .wraddress(wraddress),
    .wren(wren), .rdaddress(rdaddress), .q(q_new)
  );

  always @(posedge clock) begin
    if (rst_n === 1'b1 && wren === 1'b1)
      assert (!$isunknown(wraddress)) else $error("wraddress is X while wren=1");
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // One clock cycle: drive at negedge, predict q for both modes from the model, update model.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] d,
                      input logic [4:0] ra, output logic [31:0] e_old, output logic [31:0] e_new);
    @(negedge clock);
    wren = we; wraddress = wa; data = d; rdaddress = ra;
    @(posedge clock);
    e_old = model.exists(int'(ra)) ? model[int'(ra)] : 32'h0;
    e_new = (we && wa == ra) ? d : e_old;
    if (we) model[int'(wa)] = d;
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act_old, input logic [31:0] exp_old,
                     input logic [31:0] act_new, input logic [31:0] exp_new);
    n_checks++;
    if (act_old !== exp_old) begin
      n_fail++;
      $display("FAIL %s (RDW_NEW=0): q=%h required %h", name, act_old, exp_old);
    end
    n_checks++;
    if (act_new !== exp_new) begin
      n_fail++;
      $display("FAIL %s (RDW_NEW=1): q=%h required %h", name, act_new, exp_new);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model.delete();
    #1;
    if (q_old !== 32'h0 || q_new !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_q: q_old=%h q_new=%h required 0", q_old, q_new);
    end
    n_checks++;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic test_unwritten();
    logic [31:0] e0, e1;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'(i), $urandom, 5'(i), e0, e1);
      cmp("unwritten_read", q_old, 32'h0, q_new, 32'h0);
    end
  endtask

  task automatic test_rdw_same_addr();
    logic [31:0] e0, e1;
    step(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, e0, e1);
    cmp("rdw_same_addr", q_old, 32'h0, q_new, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'h0, 5'd7, e0, e1);
    cmp("rdw_followup", q_old, 32'hDEADBEEF, q_new, 32'hDEADBEEF);
  endtask

  task automatic test_wren_gate();
    logic [31:0] e0, e1;
    step(1'b1, 5'd0, 32'd10, 5'd1, e0, e1);
    step(1'b0, 5'd0, 32'd15, 5'd0, e0, e1);
    cmp("wren_low_read", q_old, 32'd10, q_new, 32'd10);
    step(1'b0, 5'd0, 32'd15, 5'd0, e0, e1);
    cmp("wren_low_no_store", q_old, 32'd10, q_new, 32'd10);
  endtask

  task automatic test_fill_reverse();
    logic [31:0] e0, e1;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 5'(i), 32'(i * 3), 5'(31 - i), e0, e1);
      cmp("fill_concurrent_read", q_old, e0, q_new, e1);
    end
    for (int i = 31; i >= 0; i--) begin
      step(1'b0, 5'(i), 32'hFFFF_FFFF, 5'(i), e0, e1);
      cmp("reverse_readback", q_old, 32'(i * 3), q_new, 32'(i * 3));
    end
  endtask

  task automatic test_diff_addr();
    logic [31:0] e0, e1;
    step(1'b1, 5'd9, 32'h99, 5'd0, e0, e1);
    step(1'b1, 5'd4, 32'h55, 5'd9, e0, e1);
    cmp("rdw_diff_addr", q_old, 32'h99, q_new, 32'h99);
    step(1'b0, 5'd4, 32'h0, 5'd4, e0, e1);
    cmp("diff_addr_later", q_old, 32'h55, q_new, 32'h55);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, e1;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      step(1'b1, 5'd13, d, 5'd0, e0, e1);
      step(1'b0, 5'd0, 32'h0, 5'd13, e0, e1);
      cmp("back_to_back_last_wins", q_old, d, q_new, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] e0, e1;
    logic [4:0]  wa, ra;
    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom, ra, e0, e1);
      cmp("random", q_old, e0, q_new, e1);
    end
  endtask

  task automatic test_async_reset_mid();
    logic [31:0] e0, e1;
    step(1'b1, 5'd2, 32'h1234, 5'd3, e0, e1);
    step(1'b0, 5'd0, 32'h0, 5'd2, e0, e1);
    cmp("pre_reset_read", q_old, 32'h1234, q_new, 32'h1234);
    #2 rst_n = 1'b0;
    model.delete();
    #1;
    cmp("async_reset_no_edge", q_old, 32'h0, q_new, 32'h0);
    @(negedge clock);
    wren = 1'b1; wraddress = 5'd2; data = 32'hBAD0; rdaddress = 5'd2;
    @(posedge clock);
    #1;
    cmp("reset_hold", q_old, 32'h0, q_new, 32'h0);
    @(negedge clock);
    wren = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd2, e0, e1);
    cmp("post_reset_invalid", q_old, 32'h0, q_new, 32'h0);
  endtask

  initial begin
    test_reset();
    test_unwritten();
    test_rdw_same_addr();
    test_wren_gate();
    test_fill_reverse();
    test_diff_addr();
    test_back_to_back();
    test_random();
    test_async_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
